// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter return-address stack.
// Holds the default PC width and depth plus the decoded stack operation type.
package pc_stack_pkg;

    localparam int PC_W           = 32;
    localparam int PC_STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_OVERFLOW,
        OP_UNDERFLOW,
        OP_PUSH_UNDER
    } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x W register file for the return-address stack: one synchronous
// write port, one combinational read port, no reset.
module stack_mem #(
    parameter  int W     = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pc_stack.sv
// LIFO return-address stack for the DSP program counter. The top entry is
// presented combinationally so the PC mux never waits for a read cycle.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter  int W     = PC_W,
    parameter  int DEPTH = PC_STACK_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0] r_sp;
    logic          r_overflow;
    logic          r_underflow;

    stack_op_e     w_op;
    logic [AW-1:0] w_topIdx;
    logic [CW-1:0] w_spNext;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [W-1:0]  w_rdata;
    logic          w_overflowNext;
    logic          w_underflowNext;

    assign empty    = (r_sp == '0);
    assign full     = (r_sp == CW'(DEPTH));
    assign count    = r_sp;
    // Low AW bits wrap correctly for sp == DEPTH when DEPTH is a power of two.
    assign w_topIdx = r_sp[AW-1:0] - AW'(1);

    always_comb begin
        w_op = OP_IDLE;
        if (enable) begin
            unique case ({push, pop})
                2'b10:   w_op = full  ? OP_OVERFLOW   : OP_PUSH;
                2'b01:   w_op = empty ? OP_UNDERFLOW  : OP_POP;
                2'b11:   w_op = empty ? OP_PUSH_UNDER : OP_REPLACE;
                default: w_op = OP_IDLE;
            endcase
        end
    end

    always_comb begin
        w_spNext        = r_sp;
        w_we            = 1'b0;
        w_waddr         = r_sp[AW-1:0];
        w_overflowNext  = 1'b0;
        w_underflowNext = 1'b0;
        unique case (w_op)
            OP_PUSH: begin
                w_we     = 1'b1;
                w_spNext = r_sp + CW'(1);
            end
            OP_POP: begin
                w_spNext = r_sp - CW'(1);
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_topIdx;
            end
            OP_OVERFLOW: begin
                w_overflowNext = 1'b1;
            end
            OP_UNDERFLOW: begin
                w_underflowNext = 1'b1;
            end
            OP_PUSH_UNDER: begin
                w_we            = 1'b1;
                w_spNext        = r_sp + CW'(1);
                w_underflowNext = 1'b1;
            end
            default: begin
                w_spNext = r_sp;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_spNext;
            r_overflow  <= w_overflowNext;
            r_underflow <= w_underflowNext;
        end
    end

    stack_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (push_data),
        .raddr (w_topIdx),
        .rdata (w_rdata)
    );

    assign top       = empty ? '0 : w_rdata;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
